// File: rtl/digital_output_pkg.sv
`default_nettype none
// ============================================================================
// Module  : digital_output_pkg
// Purpose : Shared register map, FSM states and operation types.
// Rev     : 1.0
// ============================================================================
package digital_output_pkg;

    localparam int unsigned c_ADDR_DATA      = 0;
    localparam int unsigned c_ADDR_SET       = 1;
    localparam int unsigned c_ADDR_CLEAR     = 2;
    localparam int unsigned c_ADDR_TOGGLE    = 3;
    localparam int unsigned c_ADDR_PULSE_LEN = 4;
    localparam int unsigned c_ADDR_PULSE     = 5;
    localparam int unsigned c_ADDR_STATUS    = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_DATA  = 3'd0,
        OP_SET   = 3'd1,
        OP_CLR   = 3'd2,
        OP_TGL   = 3'd3,
        OP_PULSE = 3'd4,
        OP_NONE  = 3'd7
    } op_t;

    // Only the addresses that drive port strobes map to an operation.
    function automatic op_t addr_to_op(input logic [31:0] a);
        case (a)
            c_ADDR_DATA:   return OP_DATA;
            c_ADDR_SET:    return OP_SET;
            c_ADDR_CLEAR:  return OP_CLR;
            c_ADDR_TOGGLE: return OP_TGL;
            c_ADDR_PULSE:  return OP_PULSE;
            default:       return OP_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// Module  : pulse_timer
// Purpose : Pulse-length down-counter with mask; flags the final count cycle.
// Rev     : 1.0
// ============================================================================
module pulse_timer #(
    parameter int N_PORTS = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [CNT_W-1:0]   load_len_i,
    input  logic [N_PORTS-1:0] load_mask_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [N_PORTS-1:0] mask_o,
    output logic               active_o,
    output logic               expire_o
);

    logic [CNT_W-1:0]   r_cnt;
    logic [N_PORTS-1:0] r_mask;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_mask <= '0;
        end else if (load_i) begin
            r_cnt  <= load_len_i;
            r_mask <= load_mask_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_mask <= '0;
            end
        end
    end

    // High during the cycle whose closing edge takes the count from 1 to 0.
    assign expire_o = (r_cnt == CNT_W'(1));
    assign active_o = (r_cnt != '0);
    assign count_o  = r_cnt;
    assign mask_o   = r_mask;

endmodule
`default_nettype wire

// File: rtl/digital_output_controller.sv
`default_nettype none
// ============================================================================
// Module  : digital_output_controller
// Purpose : Bus front end producing per-port write strobes, with pulse timer.
// Rev     : 1.0
// ============================================================================
module digital_output_controller
    import digital_output_pkg::*;
#(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               write_i,
    input  logic               read_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               done_o,
    output logic               error_o,
    input  logic [N_PORTS-1:0] port_state_i,
    output logic [N_PORTS-1:0] port_write_o,
    output logic [N_PORTS-1:0] port_data_o
);

    state_t             r_state, w_state_nxt;
    logic               w_accept, w_done;
    logic [31:0]        w_addr, w_status, w_rdata, r_rdata;
    logic               w_err, r_err, w_len_we, w_load;
    logic [N_PORTS-1:0] w_wmask, w_bus_we, w_bus_data, w_exp_mask;
    logic [N_PORTS-1:0] r_port_we, r_port_data;
    logic [CNT_W-1:0]   r_len, w_count;
    logic [N_PORTS-1:0] w_mask;
    logic               w_active, w_expire;
    logic               w_unused_bits;
    op_t                w_op;

    assign w_addr        = 32'(address_i);
    assign w_op          = addr_to_op(w_addr);
    assign w_wmask       = wdata_i[N_PORTS-1:0];
    assign w_status      = (32'(w_count) << 16) | 32'(w_active);
    assign w_exp_mask    = w_expire ? w_mask : '0;
    assign w_unused_bits = &{1'b0, wdata_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (write_i || read_i) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == IDLE) && (write_i || read_i);
        w_done   = (r_state == RESP);
    end

    // Decode of one accepted request; every effect is gated by w_accept.
    always_comb begin
        w_err      = 1'b0;
        w_rdata    = '0;
        w_bus_we   = '0;
        w_bus_data = '0;
        w_len_we   = 1'b0;
        w_load     = 1'b0;
        if (w_accept) begin
            if (write_i && read_i) begin
                w_err = 1'b1;
            end else if (write_i) begin
                if (w_addr == c_ADDR_PULSE_LEN) begin
                    w_len_we = 1'b1;
                end else begin
                    case (w_op)
                        OP_DATA: begin
                            w_bus_we   = '1;
                            w_bus_data = w_wmask;
                        end
                        OP_SET: begin
                            w_bus_we   = w_wmask;
                            w_bus_data = w_wmask;
                        end
                        OP_CLR: begin
                            w_bus_we = w_wmask;
                        end
                        OP_TGL: begin
                            w_bus_we   = w_wmask;
                            w_bus_data = w_wmask & ~port_state_i;
                        end
                        OP_PULSE: begin
                            if (r_len == '0) begin
                                w_err = 1'b1;
                            end else begin
                                w_load     = 1'b1;
                                w_bus_we   = w_wmask;
                                w_bus_data = w_wmask;
                            end
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end else begin
                case (w_addr)
                    c_ADDR_DATA:      w_rdata = 32'(port_state_i);
                    c_ADDR_SET,
                    c_ADDR_CLEAR,
                    c_ADDR_TOGGLE:    w_rdata = '0;
                    c_ADDR_PULSE_LEN: w_rdata = 32'(r_len);
                    c_ADDR_PULSE:     w_rdata = 32'(w_mask);
                    c_ADDR_STATUS:    w_rdata = w_status;
                    default:          w_err   = 1'b1;
                endcase
            end
        end
    end

    // Expiry and bus strobes share one cycle; bus data wins on the bits it writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_port_we   <= '0;
            r_port_data <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_len       <= '0;
        end else begin
            r_port_we   <= w_bus_we | w_exp_mask;
            r_port_data <= w_bus_data;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
            if (w_len_we) begin
                r_len <= wdata_i[CNT_W-1:0];
            end
        end
    end

    pulse_timer #(
        .N_PORTS (N_PORTS),
        .CNT_W   (CNT_W)
    ) u_pulse_timer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (w_load),
        .load_len_i  (r_len),
        .load_mask_i (w_wmask),
        .count_o     (w_count),
        .mask_o      (w_mask),
        .active_o    (w_active),
        .expire_o    (w_expire)
    );

    assign done_o       = w_done;
    assign rdata_o      = r_rdata;
    assign error_o      = r_err;
    assign port_write_o = r_port_we;
    assign port_data_o  = r_port_data;

endmodule
`default_nettype wire

// File: tb/tb_digital_output_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_digital_output_controller
// Purpose : Table-driven and sequenced checks with a completion scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_digital_output_controller;

    logic        clk;
    logic        rst_n_i;
    logic        write_i, read_i;
    logic [2:0]  address_i;
    logic [31:0] wdata_i, rdata_o;
    logic        done_o, error_o;
    logic [7:0]  port_state_i, port_write_o, port_data_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  we;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  ps;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  we;
        logic [7:0]  data;
    } vec_t;

    exp_t q[$];
    vec_t vecs[16];

    digital_output_controller #(
        .N_PORTS (8),
        .ADDR_W  (3),
        .CNT_W   (16)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .write_i      (write_i),
        .read_i       (read_i),
        .address_i    (address_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .port_state_i (port_state_i),
        .port_write_o (port_write_o),
        .port_data_o  (port_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus request: drive for one cycle, expect completion one cycle later.
    task automatic req(input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] wd, input logic [7:0] ps,
                       input logic [31:0] er, input logic ee,
                       input logic [7:0] ewe, input logic [7:0] edata);
        exp_t e;
        @(posedge clk);
        #1;
        write_i      = wr;
        read_i       = rd;
        address_i    = a;
        wdata_i      = wd;
        port_state_i = ps;
        e.rdata = er;
        e.err   = ee;
        e.we    = ewe;
        e.data  = edata;
        q.push_back(e);
        @(posedge clk);
        #1;
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n_i === 1'b1 && done_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rdata", rdata_o, e.rdata);
                chk("error", 32'(error_o), 32'(e.err));
                chk("port_write", 32'(port_write_o), 32'(e.we));
                chk("port_data", 32'(port_data_o), 32'(e.data));
            end
        end
    end

    initial begin
        rst_n_i      = 1'b0;
        write_i      = 1'b0;
        read_i       = 1'b0;
        address_i    = '0;
        wdata_i      = '0;
        port_state_i = '0;

        //           wr    rd    addr  wdata          ps     rdata          err   we     data
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_00A5, 8'h00, 32'h0000_0000, 1'b0, 8'hFF, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0000, 8'hA5, 32'h0000_00A5, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 32'h0000_003C, 8'h0F, 32'h0000_0000, 1'b0, 8'h3C, 8'h30};
        vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0081, 8'h0F, 32'h0000_0000, 1'b0, 8'h81, 8'h81};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0001, 8'h0F, 32'h0000_0000, 1'b0, 8'h01, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FF5A, 8'h00, 32'h0000_0000, 1'b0, 8'hFF, 8'h5A};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0010, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 3'd5, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 3'd7, 32'h0000_00FF, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 3'd7, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 3'd6, 32'h0000_00FF, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 3'd0, 32'h0000_00FF, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 1'b0, 3'd4, 32'hABCD_1234, 8'h00, 32'h0000_0000, 1'b0, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 3'd4, 32'h0000_0000, 8'h00, 32'h0000_1234, 1'b0, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 3'd6, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, 8'h00, 8'h00};

        @(negedge clk);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_ctrl", {22'h0, done_o, error_o, port_write_o}, 32'h0);
        chk("reset_data", 32'(port_data_o), 32'h0);
        @(negedge clk);
        rst_n_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].ps,
                vecs[i].rdata, vecs[i].err, vecs[i].we, vecs[i].data);
        end

        // Basic pulse: length 4 on port 1, expiry strobe four cycles after load.
        req(1'b1, 1'b0, 3'd4, 32'd4,    8'h00, 32'h0, 1'b0, 8'h00, 8'h00);
        req(1'b1, 1'b0, 3'd5, 32'h02,   8'h00, 32'h0, 1'b0, 8'h02, 8'h02);
        req(1'b0, 1'b1, 3'd6, 32'h0,    8'h02, 32'h0003_0001, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("pre_expiry_quiet", 32'(port_write_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("expiry_we", 32'(port_write_o), 32'h02);
        chk("expiry_data", 32'(port_data_o), 32'h00);
        @(negedge clk);
        chk("post_expiry_quiet", 32'(port_write_o), 32'h0);
        req(1'b0, 1'b1, 3'd6, 32'h0, 8'h00, 32'h0, 1'b0, 8'h00, 8'h00);
        req(1'b0, 1'b1, 3'd5, 32'h0, 8'h00, 32'h0, 1'b0, 8'h00, 8'h00);

        // Expiry of mask 0x06 lands on the same cycle as SET=0x02.
        req(1'b1, 1'b0, 3'd5, 32'h06, 8'h00, 32'h0, 1'b0, 8'h06, 8'h06);
        @(posedge clk);
        @(posedge clk);
        req(1'b1, 1'b0, 3'd1, 32'h02, 8'h06, 32'h0, 1'b0, 8'h06, 8'h02);
        @(posedge clk);
        @(negedge clk);
        chk("merge_single_strobe", 32'(port_write_o), 32'h0);
        req(1'b0, 1'b1, 3'd5, 32'h0, 8'h02, 32'h0, 1'b0, 8'h00, 8'h00);

        // Asynchronous reset while the count is 2 and a DATA strobe is live.
        req(1'b1, 1'b0, 3'd5, 32'h01, 8'h00, 32'h0, 1'b0, 8'h01, 8'h01);
        @(posedge clk);
        #1;
        write_i   = 1'b1;
        address_i = 3'd0;
        wdata_i   = 32'hFF;
        @(posedge clk);
        #1;
        write_i = 1'b0;
        chk("pre_reset_strobe", {23'h0, done_o, port_write_o}, {23'h0, 1'b1, 8'hFF});
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("async_reset_ctrl", {22'h0, done_o, error_o, port_write_o}, 32'h0);
        chk("async_reset_data", {24'h0, port_data_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_expiry_after_reset", 32'(port_write_o), 32'h0);
        end
        req(1'b0, 1'b1, 3'd6, 32'h0, 8'h00, 32'h0, 1'b0, 8'h00, 8'h00);
        req(1'b0, 1'b1, 3'd4, 32'h0, 8'h00, 32'h0, 1'b0, 8'h00, 8'h00);
        req(1'b0, 1'b1, 3'd5, 32'h0, 8'h00, 32'h0, 1'b0, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digital_output_controller.md
Name: digital_output_controller

Overview:
- Memory-mapped front end that sits directly upstream of the bank of single-bit digital output port registers.
- Decodes simple bus read/write requests into per-port write strobes and data: DATA, SET, CLEAR, TOGGLE and timed PULSE operations.
- Reads back the live port outputs.
- Owns the pulse-duration counter that auto-clears pulsed ports.

Parameters:
- N_PORTS, 8, number of driven output ports (1..32)
- ADDR_W, 3, word-address width of the register window
- CNT_W, 16, width of the pulse length counter

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- write_i  in  1  bus write request (single-cycle)
- read_i  in  1  bus read request (single-cycle)
- address_i  in  ADDR_W  word address
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid with done_o
- done_o  out  1  request completed
- error_o  out  1  request rejected, valid with done_o
- port_state_i  in  N_PORTS  current data_o of each output port
- port_write_o  out  N_PORTS  per-port write enable
- port_data_o  out  N_PORTS  per-port write data

Behaviour:
- Reset: all outputs 0; pulse counter 0; pulse mask 0; pulse length register 0; FSM in IDLE.
- Register map (word address):
  - 0 DATA: write drives all ports to wdata_i[N-1:0]; read returns port_state_i, zero-extended.
  - 1 SET: ports with a 1 bit are written to 1.
  - 2 CLEAR: ports with a 1 bit are written to 0.
  - 3 TOGGLE: ports with a 1 bit are written to ~port_state_i.
  - 4 PULSE_LEN: R/W, CNT_W bits.
  - 5 PULSE: write sets the masked ports to 1, loads counter = PULSE_LEN and records the mask; read returns the active pulse mask.
  - 6 STATUS: read only, bit0 = pulse active, bits[CNT_W+15:16] = remaining count.
  - 7: unmapped.
- FSM states:
  - IDLE: accepts a request on a cycle with exactly one of write_i/read_i high and moves to RESP.
  - RESP: lasts one cycle, pulses done_o, returns to IDLE.
  - Requests arriving in RESP are ignored; the master must wait for done_o.
- Latency:
  - Request in cycle t gives port_write_o/port_data_o and done_o/rdata_o in cycle t+1.
  - The port register reflects the new value at t+2.
- Strobes:
  - port_write_o[i] is high for exactly one cycle, only for affected bits.
  - port_data_o is don't-care (driven 0) where port_write_o is 0.
- Errors: done_o=1 and error_o=1, no side effects, in each of these cases:
  - write_i and read_i both high;
  - unmapped address;
  - write to STATUS;
  - PULSE write when PULSE_LEN = 0.
- wdata_i bits at or above N_PORTS are ignored.
- Pulse counter:
  - Decrements every cycle while nonzero.
  - On the transition 1->0, issues a write of 0 to every port in the pulse mask, then clears the mask.
  - A new PULSE write while active restarts the counter and replaces the mask; previously pulsed ports not in the new mask stay at 1.
- Simultaneous events:
  - If pulse expiry coincides with a bus write strobe cycle, the bus write wins for the bits it writes.
  - Expiry still clears the remaining mask bits.
  - Both are merged into one strobe cycle.
- Reset mid-operation: counter and mask clear immediately; no expiry strobe is issued.

Decomposition:
- Package digital_output_pkg:
  - register address localparams (DATA..STATUS);
  - FSM state enum (IDLE, RESP);
  - op-type enum (OP_DATA, OP_SET, OP_CLR, OP_TGL, OP_PULSE).
- Sub-module pulse_timer: counter, mask register, single-cycle expire_o with mask_o.

Test Plan:
- Reset, then write DATA=0xA5 at t -> port_write_o=0xFF, port_data_o=0xA5, done_o at t+1; read DATA with port_state_i=0xA5 -> rdata_o=0x000000A5.
- port_state_i=0x0F; write TOGGLE=0x3C -> port_write_o=0x3C, port_data_o=0x30; SET=0x81 -> data 0x81 on mask 0x81; CLEAR=0x01 -> data 0x00 on mask 0x01.
- PULSE_LEN=4, PULSE=0x02 -> bit1 written 1 at t+1; clear strobe mask 0x02, data 0 after 4 counter cycles; STATUS reads bit0=1 before expiry, 0 after.
- Pulse expiry coinciding with SET=0x02 on the same port -> single strobe, port 1 data=1; other mask bits cleared.
- Address 7, PULSE with PULSE_LEN=0, and read+write together -> done_o=1, error_o=1, port_write_o=0.
- Assert rst_n_i mid-pulse (count=2) -> all outputs 0 asynchronously; no expiry strobe after release.
